// File: rtl/serial_sub16_pkg.sv
// Shared definitions for the serial nibble-wise subtractor: slice width,
// FSM state encoding and counter sizing.
package serial_sub16_pkg;

   localparam int NIB_W = 4;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Counter width that stays legal for a single-nibble configuration.
   function automatic int cnt_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_sub16_if.sv
// Request/result bundle of the serial subtractor; master issues operands,
// slave returns the difference with borrow and overflow flags.
interface serial_sub16_if
   import serial_sub16_pkg::*;
#(
   parameter int NIBBLES = 4
) ();

   localparam int W = NIB_W * NIBBLES;

   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         bin;
   logic         busy;
   logic         done;
   logic [W-1:0] diff;
   logic         bout;
   logic         ovf;

   modport master (
      output start, a, b, bin,
      input  busy, done, diff, bout, ovf
   );

   modport slave (
      input  start, a, b, bin,
      output busy, done, diff, bout, ovf
   );

endinterface

// File: rtl/serial_sub16_nibble_sub.sv
// Combinational 4-bit carry-lookahead slice: s = x + y + cin. The caller
// feeds the inverted subtrahend so the slice performs one nibble of a - b.
module nibble_sub
   import serial_sub16_pkg::*;
(
   input  logic [NIB_W-1:0] x,
   input  logic [NIB_W-1:0] y,
   input  logic             cin,
   output logic [NIB_W-1:0] s,
   output logic             cout
);

   logic [NIB_W-1:0] p;
   logic [NIB_W-1:0] g;
   logic [NIB_W:0]   c;

   always_comb begin
      p    = x ^ y;
      g    = x & y;
      c[0] = cin;
      c[1] = g[0] | (p[0] & cin);
      c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
      c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
           | (p[2] & p[1] & p[0] & cin);
      c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
           | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);
      s    = p ^ c[NIB_W-1:0];
      cout = c[NIB_W];
   end

endmodule

// File: rtl/serial_sub16.sv
// Serial subtractor: one nibble of a - b - bin per cycle, LSB first, through a
// single reused lookahead slice; done pulses once when the result is complete.
module serial_sub16
   import serial_sub16_pkg::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   serial_sub16_if.slave bus
);

   localparam int W     = NIB_W * NIBBLES;
   localparam int CNT_W = cnt_width(NIBBLES);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(NIBBLES - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             carry_q, carry_d;
   logic [W-1:0]     a_q, a_d;
   logic [W-1:0]     b_q, b_d;
   logic [W-1:0]     diff_q, diff_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;

   logic [NIB_W-1:0] a_nib;
   logic [NIB_W-1:0] b_nib;
   logic [NIB_W-1:0] sum_nib;
   logic             cout;
   logic             accept;
   logic             last;

   assign accept = bus.start && (state_q == IDLE || state_q == DONE);
   assign last   = (cnt_q == LAST);

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (bus.start) state_d = RUN;
         RUN:     if (last) state_d = DONE;
         DONE:    state_d = bus.start ? RUN : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state_q == RUN);
      bus.done = (state_q == DONE);
      bus.diff = diff_q;
      bus.bout = bout_q;
      bus.ovf  = ovf_q;
   end

   // Select the operand nibbles addressed by the counter.
   always_comb begin
      a_nib = '0;
      b_nib = '0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            a_nib = a_q[i*NIB_W +: NIB_W];
            b_nib = b_q[i*NIB_W +: NIB_W];
         end
      end
   end

   nibble_sub u_nibble_sub (
      .x    (a_nib),
      .y    (~b_nib),
      .cin  (carry_q),
      .s    (sum_nib),
      .cout (cout)
   );

   // NOTE: every variable gets a hold default first, so no path leaves one
   // unassigned and no latch is inferred.
   always_comb begin
      cnt_d   = cnt_q;
      carry_d = carry_q;
      a_d     = a_q;
      b_d     = b_q;
      diff_d  = diff_q;
      bout_d  = bout_q;
      ovf_d   = ovf_q;
      if (accept) begin
         a_d     = bus.a;
         b_d     = bus.b;
         cnt_d   = '0;
         carry_d = ~bus.bin;
      end else if (state_q == RUN) begin
         for (int i = 0; i < NIBBLES; i++) begin
            if (cnt_q == CNT_W'(i)) diff_d[i*NIB_W +: NIB_W] = sum_nib;
         end
         carry_d = cout;
         cnt_d   = last ? '0 : cnt_q + CNT_W'(1);
         if (last) begin
            // Carry out of a + ~b + ~bin is the inverse of the unsigned borrow.
            bout_d = ~cout;
            ovf_d  = (a_q[W-1] != b_q[W-1]) && (sum_nib[NIB_W-1] != a_q[W-1]);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         diff_q  <= '0;
         bout_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         diff_q  <= diff_d;
         bout_q  <= bout_d;
         ovf_q   <= ovf_d;
      end
   end

endmodule

// File: tb/tb_serial_sub16.sv
// Directed bench for serial_sub16: hand-computed vectors, latency, ignored
// restart, mid-run reset and back-to-back operation.
module tb_serial_sub16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_checks = 0;
   int   n_errors = 0;
   time  t_done = 0;
   time  t_prev = 0;

   always #5 clk = ~clk;

   serial_sub16_if #(.NIBBLES(4)) bus ();

   serial_sub16 #(.NIBBLES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present a request, let one edge accept it, then scramble the inputs.
   task automatic issue(input logic [15:0] av, input logic [15:0] bv, input logic bi);
      bus.start = 1'b1;
      bus.a     = av;
      bus.b     = bv;
      bus.bin   = bi;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      bus.a     = ~av;
      bus.b     = ~bv;
      bus.bin   = ~bi;
   endtask

   // Called one step after the accepting edge; ends on a falling edge.
   task automatic wait_done(input string tag, input logic [15:0] ed, input logic eb,
                            input logic eo, input bit inject, input bit chain,
                            input logic [15:0] ca, input logic [15:0] cb, input logic cbi);
      int lat = 0;
      @(negedge clk);
      check({tag, "_busy"}, 32'(bus.busy), 32'd1);
      while (!bus.done && lat < 20) begin
         if (inject && lat == 1) begin
            bus.start = 1'b1;
            bus.a     = 16'h5555;
            bus.b     = 16'h1111;
            bus.bin   = 1'b1;
         end
         if (inject && lat == 2) bus.start = 1'b0;
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      t_prev = t_done;
      t_done = $time;
      check({tag, "_lat"}, 32'(lat), 32'd4);
      check({tag, "_diff"}, 32'(bus.diff), 32'(ed));
      check({tag, "_bout"}, 32'(bus.bout), 32'(eb));
      check({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
      check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
      if (chain) begin
         issue(ca, cb, cbi);
      end else begin
         @(posedge clk);
         @(negedge clk);
         check({tag, "_pulse"}, 32'(bus.done), 32'd0);
         check({tag, "_hold"}, 32'(bus.diff), 32'(ed));
      end
   endtask

   task automatic run_op(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic bi, input logic [15:0] ed, input logic eb, input logic eo);
      issue(av, bv, bi);
      wait_done(tag, ed, eb, eo, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
   endtask

   initial begin
      int extra_done;
      int extra_busy;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.bin   = 1'b0;
      #12;
      check("rst_busy", 32'(bus.busy), 32'd0);
      check("rst_done", 32'(bus.done), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_bout", 32'(bus.bout), 32'd0);
      check("rst_ovf", 32'(bus.ovf), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      run_op("basic", 16'h1234, 16'h0034, 1'b0, 16'h1200, 1'b0, 1'b0);
      run_op("under", 16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0);
      run_op("eq_bin", 16'h0005, 16'h0005, 1'b1, 16'hFFFF, 1'b1, 1'b0);
      run_op("ovf_neg", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1);
      run_op("ovf_pos", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1);
      run_op("max_bin", 16'hFFFF, 16'h0000, 1'b1, 16'hFFFE, 1'b0, 1'b0);

      // A second request two cycles into RUN must be dropped.
      issue(16'h1234, 16'h0034, 1'b0);
      wait_done("ignore", 16'h1200, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 16'h0, 1'b0);
      extra_done = 0;
      extra_busy = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (bus.done) extra_done++;
         if (bus.busy) extra_busy++;
      end
      check("ignore_no_redo", 32'(extra_done), 32'd0);
      check("ignore_no_busy", 32'(extra_busy), 32'd0);

      // Reset in the second RUN cycle, after nibble 0 (0x8) has been written.
      issue(16'h00F9, 16'h0001, 1'b0);
      @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check("mrst_busy", 32'(bus.busy), 32'd0);
      check("mrst_done", 32'(bus.done), 32'd0);
      check("mrst_diff", 32'(bus.diff), 32'd0);
      check("mrst_bout", 32'(bus.bout), 32'd0);
      check("mrst_ovf", 32'(bus.ovf), 32'd0);
      extra_done = 0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         if (bus.done) extra_done++;
      end
      check("mrst_no_done", 32'(extra_done), 32'd0);
      rst_n = 1'b1;
      run_op("post_rst", 16'h4321, 16'h1111, 1'b0, 16'h3210, 1'b0, 1'b0);

      // Back-to-back: new request presented during DONE.
      issue(16'h1000, 16'h0001, 1'b0);
      wait_done("b2b_1", 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1, 16'h0003, 16'h0005, 1'b1);
      wait_done("b2b_2", 16'hFFFD, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 1'b0);
      check("b2b_gap", 32'((t_done - t_prev) / 10), 32'd5);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/serial_sub16.md
SERIAL_SUB16 -- requirements
Module: serial_sub16

Interface
REQ-001 Parameter NIBBLES, default 4: number of 4-bit slices; operand width W = 4*NIBBLES.
REQ-002 clk  input  1  single system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset; asynchronous, active-low.
REQ-004 start  input  1  request; sampled on the rising edge of clk.
REQ-005 a  input  W  minuend; sampled only on the edge that accepts start.
REQ-006 b  input  W  subtrahend; sampled only on the edge that accepts start.
REQ-007 bin  input  1  borrow-in; sampled only on the edge that accepts start.
REQ-008 busy  output  1  high while a subtraction is in progress.
REQ-009 done  output  1  one-cycle pulse; result valid.
REQ-010 diff  output  W  a - b - bin, modulo 2^W.
REQ-011 bout  output  1  unsigned borrow-out; high when a < b + bin.
REQ-012 ovf  output  1  two's-complement overflow of the subtraction.

Function
REQ-013 FSM states SHALL be IDLE, RUN and DONE, with IDLE as the reset state.
REQ-014 IDLE/DONE with start=1 SHALL go to RUN, latch a, b and bin, clear the nibble counter and set the internal carry to ~bin.
REQ-015 IDLE with start=0 SHALL stay in IDLE; DONE with start=0 SHALL go to IDLE.
REQ-016 RUN SHALL compute one nibble per cycle, LSB first: nibble i = a[i] + ~b[i] + carry, written to diff[i]; carry register updated.
REQ-017 RUN SHALL go to DONE on the edge that writes nibble NIBBLES-1; the nibble counter SHALL wrap to 0 on that edge.
REQ-018 Latency: with start accepted at edge k, done SHALL be high for the cycle after edge k+NIBBLES (k+4 by default), for exactly one cycle.
REQ-019 busy SHALL be 1 in RUN only; done SHALL be 1 in DONE only.
REQ-020 bout SHALL be the inverse of the final carry; ovf = (a[W-1] != b[W-1]) && (diff[W-1] != a[W-1]), on latched operands.
REQ-021 bout and ovf SHALL update on the edge entering DONE.
REQ-022 diff, bout and ovf SHALL hold until the next accepted start.
REQ-023 Intermediate diff nibbles MAY be visible during RUN; the result is only valid while done=1 and afterwards.
REQ-024 start during RUN SHALL be ignored: no restart and no operand capture.
REQ-025 start in DONE SHALL be accepted: back-to-back operation, no idle cycle.
REQ-026 Changes on a, b or bin after acceptance SHALL NOT affect the result.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, busy=0, done=0, diff=0, bout=0, ovf=0 and clear the counter, carry and operand registers, including mid-RUN.
REQ-028 The first start SHALL be accepted on the first rising edge after rst_n deasserts.

Structure
REQ-029 The state encoding (IDLE, RUN, DONE) and the nibble width constant 4 SHALL live in a shared package.
REQ-030 One sub-module, nibble_sub, SHALL be a purely combinational 4-bit carry-lookahead slice: inputs x[3:0], y[3:0], cin; outputs s[3:0], cout. It is instantiated once and reused each cycle.

Verification
REQ-031 a=0x1234, b=0x0034, bin=0 -> diff=0x1200, bout=0, ovf=0; done exactly 4 cycles after the start edge.
REQ-032 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, ovf=0. Also a=0x0005, b=0x0005, bin=1 -> diff=0xFFFF, bout=1, ovf=0.
REQ-033 a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0, ovf=1. Also a=0x7FFF, b=0xFFFF -> diff=0x8000, bout=1, ovf=1.
REQ-034 start again 2 cycles into RUN with different operands -> first result unchanged; done pulses once; second request dropped.
REQ-035 rst_n low in the 2nd RUN cycle -> all outputs 0 immediately, no done pulse; next start after release gives a correct result.
REQ-036 start held high through DONE with new operands -> second done exactly 5 cycles after the first; both results correct.
